// File: rtl/mem_arbiter.sv
// Three-port arbiter for a single external 16-bit asynchronous memory.
// VGA has priority, IO/CPU share round-robin, and VGA never wins twice in a row while others wait.
module mem_arbiter #(
  parameter int AW            = 21,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          vga_req,
  input  logic          io_req,
  input  logic          cpu_req,
  input  logic [AW-1:0] vga_addr,
  input  logic [AW-1:0] io_addr,
  input  logic [AW-1:0] cpu_addr,
  input  logic          io_we,
  input  logic          cpu_we,
  input  logic [15:0]   io_wdata,
  input  logic [15:0]   cpu_wdata,
  output logic          vga_ack,
  output logic          io_ack,
  output logic          cpu_ack,
  output logic [15:0]   rdata,
  output logic [AW-1:0] mem_a,
  output logic [15:0]   mem_dout,
  output logic          mem_oe,
  output logic          mem_we_n,
  input  logic [15:0]   mem_din,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
  typedef enum logic [1:0] {G_NONE, G_VGA, G_IO, G_CPU} grant_t;

  localparam logic [2:0] LAST_CNT = 3'(ACCESS_CYCLES - 1);

  state_t          r_state;
  state_t          w_next;
  grant_t          r_gnt;
  grant_t          w_win;
  logic [2:0]      r_cnt;
  logic            r_rr_cpu;
  logic            r_vga_last;
  logic            r_we;
  logic [AW-1:0]   r_mem_a;
  logic [15:0]     r_dout;
  logic [15:0]     r_rdata;
  logic            w_last;
  logic            w_pick_nv;

  assign w_last    = (r_cnt == LAST_CNT);
  // A non-VGA requester wins whenever VGA is idle or VGA took the previous grant.
  assign w_pick_nv = (io_req | cpu_req) & (r_vga_last | ~vga_req);

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    w_win = G_NONE;
    if (w_pick_nv) begin
      if (io_req && cpu_req) w_win = r_rr_cpu ? G_CPU : G_IO;
      else if (io_req)       w_win = G_IO;
      else                   w_win = G_CPU;
    end else if (vga_req) begin
      w_win = G_VGA;
    end
  end

  // NOTE: sequential state uses non-blocking assignments and an asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    busy     = 1'b0;
    mem_oe   = 1'b0;
    mem_we_n = 1'b1;
    vga_ack  = 1'b0;
    io_ack   = 1'b0;
    cpu_ack  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_win != G_NONE) w_next = S_ACCESS;
      end
      S_ACCESS: begin
        busy     = 1'b1;
        mem_oe   = r_we;
        // The last strobe cycle releases WE for hold time, unless it is the only cycle.
        mem_we_n = ~(r_we & (~w_last | (ACCESS_CYCLES == 1)));
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        vga_ack = (r_gnt == G_VGA);
        io_ack  = (r_gnt == G_IO);
        cpu_ack = (r_gnt == G_CPU);
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gnt      <= G_NONE;
      r_cnt      <= 3'd0;
      r_rr_cpu   <= 1'b0;
      r_vga_last <= 1'b0;
      r_we       <= 1'b0;
      r_mem_a    <= '0;
      r_dout     <= 16'h0000;
      r_rdata    <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= 3'd0;
          if (w_win != G_NONE) r_gnt <= w_win;
          case (w_win)
            G_VGA: begin
              r_mem_a    <= vga_addr;
              r_we       <= 1'b0;
              r_vga_last <= 1'b1;
            end
            G_IO: begin
              r_mem_a    <= io_addr;
              r_we       <= io_we;
              r_dout     <= io_wdata;
              r_vga_last <= 1'b0;
              r_rr_cpu   <= ~r_rr_cpu;
            end
            G_CPU: begin
              r_mem_a    <= cpu_addr;
              r_we       <= cpu_we;
              r_dout     <= cpu_wdata;
              r_vga_last <= 1'b0;
              r_rr_cpu   <= ~r_rr_cpu;
            end
            default: ;
          endcase
        end
        S_ACCESS: begin
          if (w_last) begin
            r_cnt <= 3'd0;
            if (!r_we) r_rdata <= mem_din;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_a    = r_mem_a;
  assign mem_dout = r_dout;
  assign rdata    = r_rdata;

endmodule
